// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receiver and its helpers.
//   DATA_BITS        : data bits per frame (fixed at 8)
//   UART_DIV_W       : width of the half-bit divider input
//   uart_rx_state_t  : receiver FSM states; ST_* are the same codes as plain
//                      logic [1:0] constants for case labels and debug ports
//   clamp_div()      : maps divider values 0 and 1 to 1
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int UART_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

    // A zero-length half period would never expire, so 0 and 1 both run at 1.
    function automatic logic [UART_DIV_W-1:0] clamp_div(input logic [UART_DIV_W-1:0] d);
        return (d < UART_DIV_W'(2)) ? UART_DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// uart_rx_baud_cnt: loadable down-counter with an expiry pulse.
//   clock    : rising-edge system clock
//   reset    : asynchronous active-low reset, counter clears to 0
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load; expiry occurs load_val cycles after the load
//   expire   : high for the cycle in which the count is 1 (the final edge)
//   idle     : high when the counter has run out and sits at 0
module uart_rx_baud_cnt
    import uart_pkg::*;
#(
    parameter int W = UART_DIV_W + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire,
    output logic         idle
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged while the count is 1 so the owner can reload on the
    // same edge that would otherwise take the counter to 0.
    assign expire = (cnt_q == W'(1));
    assign idle   = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, samples each bit at its centre.
//   clock     : rising-edge system clock
//   reset     : asynchronous active-low reset
//   clock_div : half bit period in clock cycles, latched at start detection
//   rx        : serial line, idle high
//   rx_data   : last valid received byte, held until the next valid frame
//   rx_done   : one-cycle strobe, same edge as rx_data update; no back-pressure,
//               the consumer must take rx_data while rx_done is high or later
//   dbg_state : current FSM state (ST_IDLE/ST_START/ST_DATA/ST_STOP)
// Build option: UART_RX_SYNC_EN adds a two-flop synchronizer (reset to 1) on
// rx; all sample points then fall two cycles later relative to the pin.
module uart_rx
    import uart_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [UART_DIV_W-1:0] clock_div,
    input  logic                  rx,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_done,
    output logic [1:0]            dbg_state
);

    localparam int         CNT_W    = UART_DIV_W + 1;
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    logic [1:0]            state_q, state_d;
    logic [UART_DIV_W-1:0] div_q, div_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  done_q, done_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_val;
    logic                  cnt_expire;
    logic                  cnt_idle;
    logic [CNT_W-1:0]      bit_period;

    assign bit_period = {div_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    div_d    = clamp_div(clock_div);
                    cnt_load = 1'b1;
                    cnt_val  = {1'b0, clamp_div(clock_div)};
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_expire) begin
                    if (!rx_s) begin
                        cnt_load = 1'b1;
                        cnt_val  = bit_period;
                        idx_d    = 3'd0;
                        state_d  = ST_DATA;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_expire) begin
                    shift_d[idx_q] = rx_s;
                    cnt_load       = 1'b1;
                    cnt_val        = bit_period;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_expire) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    // On a framing error the counter is left to run out; the
                    // FSM parks here until the line returns high.
                end else if (cnt_idle && rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    uart_rx_baud_cnt #(
        .W (CNT_W)
    ) u_baud_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (cnt_expire),
        .idle     (cnt_idle)
    );

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (default build, no synchronizer).
module tb_uart_rx;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] clock_div = 16'd217;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [1:0]  dbg_state;

  uart_rx dut (
    .clock     (clock),
    .reset     (reset),
    .clock_div (clock_div),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  // Number of rising edges so far; edge k leaves cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [7:0]  got_q[$];
  int          got_cyc_q[$];
  int          width_err = 0;
  bit          prev_done = 1'b0;
  logic [7:0]  model_data = 8'h00;

  always @(negedge clock) begin
    if (rx_done === 1'b1) begin
      if (prev_done) width_err++;
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
    end
    prev_done = (rx_done === 1'b1);
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_done;
  } vec_t;

  function automatic int eff_div(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A valid frame whose start edge is cycle s delivers at edge s + 19*div.
  task automatic expect_frame(input logic [7:0] b, input int s, input int e);
    exp_q.push_back(b);
    exp_cyc_q.push_back(s + 19 * e);
    model_data = b;
  endtask

  task automatic check_sb(input string name);
    check_int({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check_int({name, "_data"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
      check_int({name, "_cycle"}, got_cyc_q.pop_front(), exp_cyc_q.pop_front());
    end
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // ---------------- driver ----------------
  // Drives one 8N1 frame with bit period 2*e. aligned: start at the next
  // falling edge; otherwise start right now. short_stop: release the stop bit
  // as soon as rx_done is seen and return 3 time units after that edge.
  task automatic send_frame(input logic [7:0] b, input int e, input bit stop_val,
                            input bit aligned, input bit short_stop, output int start);
    bit seen;
    int k;
    if (aligned) @(negedge clock);
    rx = 1'b0;
    start = cyc + 1;
    repeat (2 * e) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (2 * e) @(negedge clock);
    end
    rx = stop_val;
    if (short_stop) begin
      seen = 1'b0;
      k = 0;
      while (!seen && k < 4 * e + 8) begin
        @(posedge clock);
        #1;
        if (rx_done === 1'b1) seen = 1'b1;
        k++;
      end
      check_int("done_timeout", int'(seen), 1);
      #2;
    end else begin
      repeat (2 * e) @(negedge clock);
    end
  endtask

  // ---------------- test ----------------
  vec_t        vt[6];
  int          s;
  int          s2;
  int          e;
  int          d;
  bit          st;
  logic [7:0]  b;

  initial begin
    vt[0] = '{8'hA5, 4, 1'b1, 8'hA5, 1'b1};
    vt[1] = '{8'h55, 8, 1'b0, 8'hA5, 1'b0};
    vt[2] = '{8'h00, 1, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'hFF, 0, 1'b1, 8'hFF, 1'b1};
    vt[4] = '{8'h81, 3, 1'b1, 8'h81, 1'b1};
    vt[5] = '{8'h7E, 2, 1'b0, 8'h81, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    check_int("reset_data", int'(rx_data), 0);
    check_int("reset_done", int'(rx_done), 0);
    check_int("reset_state", int'(dbg_state), int'(ST_IDLE));
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_int("idle_data", int'(rx_data), 0);

    // Table-driven frames, including divider clamp and framing errors
    for (int i = 0; i < 6; i++) begin
      clock_div = 16'(vt[i].div);
      e = eff_div(vt[i].div);
      send_frame(vt[i].data, e, vt[i].stop, 1'b1, 1'b0, s);
      if (!vt[i].stop) begin
        repeat (40) @(negedge clock);
        check_int("stuck_low_frames", got_q.size(), 0);
        check_int("stuck_low_state", int'(dbg_state), int'(ST_STOP));
        rx = 1'b1;
      end
      if (vt[i].exp_done) expect_frame(vt[i].exp_data, s, e);
      repeat (4) @(negedge clock);
      check_int("vec_data", int'(rx_data), int'(vt[i].exp_data));
      if (vt[i].div == 4 && got_cyc_q.size() > 0)
        check_int("latency_77", got_cyc_q[0] - s + 1, 77);
      check_sb("vec");
    end

    // Back-to-back frames, each start 3 time units after the previous rx_done
    clock_div = 16'd217;
    rx = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(8'h41, 217, 1'b1, 1'b1, 1'b1, s); expect_frame(8'h41, s, 217);
    send_frame(8'h44, 217, 1'b1, 1'b0, 1'b1, s); expect_frame(8'h44, s, 217);
    send_frame(8'h41, 217, 1'b1, 1'b0, 1'b1, s); expect_frame(8'h41, s, 217);
    send_frame(8'h4D, 217, 1'b1, 1'b0, 1'b1, s); expect_frame(8'h4D, s, 217);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check_int("b2b_last_data", int'(rx_data), 8'h4D);
    check_sb("b2b");

    // Glitch: 100 low cycles; rejected only at the start-bit centre (217)
    @(negedge clock);
    rx = 1'b0;
    s = cyc + 1;
    repeat (100) @(negedge clock);
    rx = 1'b1;
    while (cyc < s + 216) @(negedge clock);
    check_int("glitch_pending", int'(dbg_state), int'(ST_START));
    @(negedge clock);
    check_int("glitch_reject", int'(dbg_state), int'(ST_IDLE));
    repeat (300) @(negedge clock);
    check_int("glitch_data", int'(rx_data), int'(model_data));
    check_sb("glitch");

    // Asynchronous reset in the middle of data bit 3 of 0xFF
    clock_div = 16'd8;
    @(negedge clock);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    rx = 1'b1;
    repeat (3 * 16 + 8) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_int("abort_data", int'(rx_data), 0);
    check_int("abort_done", int'(rx_done), 0);
    check_int("abort_state", int'(dbg_state), int'(ST_IDLE));
    model_data = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_sb("abort");
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, s);
    expect_frame(8'h3C, s, 8);
    repeat (4) @(negedge clock);
    check_int("after_abort_data", int'(rx_data), 8'h3C);
    check_sb("after_abort");

    // clock_div changes mid-frame; the next frame picks up the new value
    clock_div = 16'd217;
    fork
      send_frame(8'h41, 217, 1'b1, 1'b1, 1'b0, s);
      begin
        repeat (1500) @(negedge clock);
        clock_div = 16'd100;
      end
    join
    expect_frame(8'h41, s, 217);
    repeat (4) @(negedge clock);
    check_int("divchg_first", int'(rx_data), 8'h41);
    send_frame(8'h4D, 100, 1'b1, 1'b1, 1'b0, s2);
    expect_frame(8'h4D, s2, 100);
    repeat (4) @(negedge clock);
    check_int("divchg_second", int'(rx_data), 8'h4D);
    check_sb("divchg");

    // Randomized frames against the reference model
    for (int n = 0; n < 30; n++) begin
      d  = int'($urandom_range(0, 10));
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) != 0);
      e  = eff_div(d);
      clock_div = 16'(d);
      rx = 1'b1;
      repeat ($urandom_range(2, 6)) @(negedge clock);
      send_frame(b, e, st, 1'b1, 1'b0, s);
      if (st) begin
        expect_frame(b, s, e);
      end else begin
        repeat ($urandom_range(1, 5)) @(negedge clock);
        rx = 1'b1;
      end
      repeat (3) @(negedge clock);
      check_int("rand_data", int'(rx_data), int'(model_data));
    end
    check_sb("rand");

    check_int("done_pulse_width", width_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
